// File: rtl/glitc_phase_shift_responder.sv
// Phase-shift responder for the GLITC clocking block.
// Accepts one-cycle phase-shift strobes, waits a fixed latency, then steps a
// wrapping phase index by one position and reports completion with a pulse.
// Requests that arrive while a shift is in flight are dropped and latched as
// a sticky protocol error.

module glitc_phase_shift_responder #(
    parameter int PS_LATENCY       = 12,
    parameter int STEPS_PER_PERIOD = 224
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps_en_i,
    input  logic       ps_increment_ndecrement_i,
    output logic       ps_done_o,
    output logic       busy_o,
    output logic [7:0] phase_o,
    output logic       wrapped_o,
    output logic       protocol_error_o,
    input  logic       clear_error_i
);

    // Counter load value: the counter is loaded on the accepting edge and the
    // DONE transition happens on the edge after it reaches zero, which puts
    // ps_done_o exactly PS_LATENCY edges after the accepting edge.
    localparam logic [7:0] LAT_LOAD  = 8'(PS_LATENCY - 1);
    localparam logic [7:0] PHASE_MAX = 8'(STEPS_PER_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t     state_r;
    logic [7:0] lat_cnt_r;
    logic       dir_inc_r;
    logic [7:0] phase_r;
    logic       done_r;
    logic       busy_r;
    logic       wrapped_r;
    logic       err_r;

    // Shift sequencer: accept, count down the latency, then step the phase.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r   <= IDLE;
            lat_cnt_r <= 8'd0;
            dir_inc_r <= 1'b0;
            phase_r   <= 8'd0;
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
            wrapped_r <= 1'b0;
        end else begin
            done_r    <= 1'b0;
            wrapped_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ps_en_i) begin
                        dir_inc_r <= ps_increment_ndecrement_i;
                        lat_cnt_r <= LAT_LOAD;
                        busy_r    <= 1'b1;
                        state_r   <= SHIFTING;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                SHIFTING: begin
                    if (lat_cnt_r == 8'd0) begin
                        // Phase moves in the same cycle the done pulse is shown.
                        done_r  <= 1'b1;
                        state_r <= DONE;
                        if (dir_inc_r) begin
                            if (phase_r == PHASE_MAX) begin
                                phase_r   <= 8'd0;
                                wrapped_r <= 1'b1;
                            end else begin
                                phase_r   <= phase_r + 8'd1;
                            end
                        end else begin
                            if (phase_r == 8'd0) begin
                                phase_r   <= PHASE_MAX;
                                wrapped_r <= 1'b1;
                            end else begin
                                phase_r   <= phase_r - 8'd1;
                            end
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - 8'd1;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    lat_cnt_r <= 8'd0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // Sticky protocol error: a strobe outside IDLE sets it; setting beats clearing.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            err_r <= 1'b0;
        end else if (ps_en_i && (state_r != IDLE)) begin
            err_r <= 1'b1;
        end else if (clear_error_i) begin
            err_r <= 1'b0;
        end else begin
            err_r <= err_r;
        end
    end

    assign ps_done_o        = done_r;
    assign busy_o           = busy_r;
    assign phase_o          = phase_r;
    assign wrapped_o        = wrapped_r;
    assign protocol_error_o = err_r;

endmodule

// File: tb/tb_glitc_phase_shift_responder.sv
// Scoreboard bench for glitc_phase_shift_responder (default parameters).
// The stimulus process pushes the expected completion (edge, phase, wrap) for
// every accepted request; the monitor checks outputs on every falling edge.

module tb_glitc_phase_shift_responder;

    localparam int LAT   = 12;
    localparam int STEPS = 224;

    logic       clk = 1'b0;
    logic       rst_n_i;
    logic       ps_en_i;
    logic       ps_increment_ndecrement_i;
    logic       ps_done_o;
    logic       busy_o;
    logic [7:0] phase_o;
    logic       wrapped_o;
    logic       protocol_error_o;
    logic       clear_error_i;

    typedef struct {
        int         due;
        logic [7:0] ph;
        logic       wr;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    logic rst_smp  = 1'b0;
    logic exp_err  = 1'b0;
    int   stim_phase = 0;
    logic [7:0] cur_phase = 8'd0;
    int   n_chk  = 0;
    int   n_fail = 0;

    glitc_phase_shift_responder #(
        .PS_LATENCY(LAT),
        .STEPS_PER_PERIOD(STEPS)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n_i),
        .ps_en_i(ps_en_i),
        .ps_increment_ndecrement_i(ps_increment_ndecrement_i),
        .ps_done_o(ps_done_o),
        .busy_o(busy_o),
        .phase_o(phase_o),
        .wrapped_o(wrapped_o),
        .protocol_error_o(protocol_error_o),
        .clear_error_i(clear_error_i)
    );

    always #5 clk = ~clk;

    // Edge index and reset sample of the most recent rising edge.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        rst_smp  <= rst_n_i;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: compares every output against the scoreboard each cycle.
    always @(negedge clk) begin
        if (edge_cnt > 0) begin
            if (!rst_smp) begin
                q.delete();
                cur_phase = 8'd0;
                chk("rst_done",  int'(ps_done_o), 0);
                chk("rst_busy",  int'(busy_o), 0);
                chk("rst_phase", int'(phase_o), 0);
                chk("rst_wrap",  int'(wrapped_o), 0);
                chk("rst_err",   int'(protocol_error_o), 0);
            end else begin
                chk("busy", int'(busy_o), (q.size() != 0) ? 1 : 0);
                chk("perr", int'(protocol_error_o), int'(exp_err));
                if (ps_done_o) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("done_edge", edge_cnt, e.due);
                        chk("done_phase", int'(phase_o), int'(e.ph));
                        chk("done_wrap", int'(wrapped_o), int'(e.wr));
                        cur_phase = e.ph;
                    end
                end else begin
                    chk("phase_hold", int'(phase_o), int'(cur_phase));
                    chk("wrap_no_done", int'(wrapped_o), 0);
                    if (q.size() != 0 && edge_cnt > q[0].due) begin
                        chk("missed_done", edge_cnt, q[0].due);
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one accepted request and record its expected completion.
    task automatic req(input logic inc);
        exp_t e;
        int   nxt;
        logic wr;
        ps_en_i = 1'b1;
        ps_increment_ndecrement_i = inc;
        tick();
        ps_en_i = 1'b0;
        wr = 1'b0;
        if (inc) begin
            if (stim_phase == STEPS - 1) begin nxt = 0; wr = 1'b1; end
            else nxt = stim_phase + 1;
        end else begin
            if (stim_phase == 0) begin nxt = STEPS - 1; wr = 1'b1; end
            else nxt = stim_phase - 1;
        end
        stim_phase = nxt;
        e.due = edge_cnt + LAT;
        e.ph  = 8'(nxt);
        e.wr  = wr;
        q.push_back(e);
    endtask

    // Wait (bounded) for the done pulse, then step into the next free cycle.
    task automatic wait_done();
        int n;
        n = 0;
        while (!ps_done_o && n < LAT + 4) begin
            tick();
            n++;
        end
        tick();
    endtask

    task automatic shift(input logic inc);
        req(inc);
        wait_done();
    endtask

    initial begin
        rst_n_i = 1'b0;
        ps_en_i = 1'b0;
        ps_increment_ndecrement_i = 1'b1;
        clear_error_i = 1'b0;

        // Reset held four cycles with the strobe toggling.
        for (int i = 0; i < 4; i++) begin
            ps_en_i = ~ps_en_i;
            tick();
        end
        ps_en_i = 1'b0;
        rst_n_i = 1'b1;
        tick();

        // Decrement from 0 wraps to 223, increment wraps back to 0.
        shift(1'b0);
        shift(1'b1);

        // Single increment 0 -> 1 with latency checked, then back to 0.
        shift(1'b1);
        shift(1'b0);

        // Full period of back-to-back increments.
        for (int i = 0; i < STEPS; i++) begin
            shift(1'b1);
        end

        // Second strobe five cycles after the first is dropped and flagged.
        req(1'b1);
        repeat (4) tick();
        ps_en_i = 1'b1;
        ps_increment_ndecrement_i = 1'b0;
        tick();
        ps_en_i = 1'b0;
        exp_err = 1'b1;
        wait_done();
        repeat (3) tick();
        clear_error_i = 1'b1;
        tick();
        clear_error_i = 1'b0;
        exp_err = 1'b0;
        tick();

        // Clear coincident with a new violation: set wins.
        req(1'b1);
        repeat (2) tick();
        ps_en_i = 1'b1;
        clear_error_i = 1'b1;
        tick();
        ps_en_i = 1'b0;
        clear_error_i = 1'b0;
        exp_err = 1'b1;
        wait_done();
        clear_error_i = 1'b1;
        tick();
        clear_error_i = 1'b0;
        exp_err = 1'b0;

        // Walk to phase 5, then reset six cycles into a shift.
        repeat (3) shift(1'b1);
        req(1'b1);
        repeat (5) tick();
        rst_n_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        stim_phase = 0;
        exp_err = 1'b0;
        repeat (20) tick();

        // One more shift after the aborted one to show recovery.
        shift(1'b1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
